// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns core byte/half/word accesses into word-aligned
// memory requests with byte enables, extends load data and reports errors.
module load_store_unit #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [31:0]      addr_q, wdata_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             capture;
    logic             req_illegal, req_misaligned;
    logic [3:0]       be;
    logic [31:0]      wdata_lanes;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;

    // Loads allow 000/001/010/100/101; stores only 000/001/010.
    always_comb begin
        req_illegal = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                             : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be          = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be          = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_code_d  = err_code_q;
        rsp_rdata_d = rsp_rdata_q;
        capture     = 1'b0;
        stall       = 1'b0;
        mem_req     = 1'b0;
        rsp_valid   = 1'b0;
        err         = 1'b0;
        case (state_q)
            IDLE: begin
                // The core is never held while reset is asserted.
                stall = req_valid && reset_n;
                if (req_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    if (req_illegal) begin
                        state_d     = ERR;
                        err_code_d  = 2'b11;
                        rsp_rdata_d = '0;
                    end else if (req_misaligned) begin
                        state_d     = ERR;
                        err_code_d  = 2'b01;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d     = RESP;
                    err_code_d  = 2'b00;
                    rsp_rdata_d = we_q ? 32'h0 : load_data;
                end else if (cnt_q == WAIT_LIMIT) begin
                    state_d     = ERR;
                    err_code_d  = 2'b10;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            ERR: begin
                rsp_valid = 1'b1;
                err       = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_code_q  <= 2'b00;
            rsp_rdata_q <= '0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_code_q  <= err_code_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (capture) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // Memory side is driven purely from captured registers so it stays stable while waiting.
    assign mem_we    = mem_req && we_q;
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_lanes;
    assign err_code  = err_code_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
